stream_demux2: RTL
==================

Name: stream_demux2

Overview:
- One-to-two stream demultiplexer; the distributing counterpart of the 2:1 select path.
- Takes one valid/ready input stream and steers each packet (beats terminated by last) to output 0 or 1.
- The destination is chosen by a select line sampled on the first beat of the packet and held until that packet's last beat.
- Each output has a one-entry register stage; each output also keeps a wrapping count of completed packets. Used on datapath/bus fan-out.

Parameters:
DATA_W, 32, width of data on input and both outputs
CNT_W, 8, width of per-output completed-packet counters

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
s_data  input  DATA_W  input beat data
s_last  input  1  marks final beat of packet
s_sel  input  1  destination (0 -> out0, 1 -> out1); sampled only on first beat
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid & s_ready
m0_data  output  DATA_W  output 0 data (registered)
m0_last  output  1  output 0 last flag (registered)
m0_valid  output  1  output 0 valid
m0_ready  input  1  output 0 consumer ready
m1_data  output  DATA_W  output 1 data (registered)
m1_last  output  1  output 1 last flag (registered)
m1_valid  output  1  output 1 valid
m1_ready  input  1  output 1 consumer ready
pkt_cnt0  output  CNT_W  packets completed on output 0
pkt_cnt1  output  CNT_W  packets completed on output 1
busy  output  1  high while a packet is in progress (state BUSY)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values (rst_n low at rising edge):
  - m0_valid = m1_valid = 0.
  - m*_data = 0, m*_last = 0.
  - pkt_cnt0 = pkt_cnt1 = 0.
  - state IDLE, route register 0, busy = 0.
  - s_ready is forced 0 combinationally while rst_n is low.
- Reset mid-packet: the partial packet and any held output beats are discarded; no counter increments.
- States:
  - IDLE: no packet open. Effective route = s_sel (combinational).
  - BUSY: packet open. Effective route = latched route register; s_sel is ignored.
- Transitions on an accepted beat (s_valid & s_ready):
  - IDLE, s_last = 0 -> BUSY; route register <= s_sel.
  - IDLE, s_last = 1 -> stays IDLE (single-beat packet).
  - BUSY, s_last = 1 -> IDLE.
  - BUSY, s_last = 0 -> stays BUSY.
  - No beat accepted -> state unchanged.
- s_ready = rst_n & (~mR_valid | mR_ready), where R = effective route. In IDLE, s_ready therefore depends combinationally on s_sel. There is no other combinational path from m*_ready to outputs.
- Output register X, evaluated each cycle:
  - Beat accepted and routed to X: mX_data <= s_data, mX_last <= s_last, mX_valid <= 1.
  - Otherwise, if mX_ready: mX_valid <= 0.
  - Otherwise: hold. Data and last stay stable while mX_valid & ~mX_ready.
- Latency: 1 cycle from input acceptance to m*_valid. Full throughput (1 beat/cycle) when the destination holds ready high.
- The non-selected output drains independently. Its stall never blocks the selected output.
- Ordering: beats within a packet leave on one output, in order. Packets to different outputs may complete out of order relative to each other.
- Counters:
  - pkt_cntX increments by 1 on the cycle mX_valid & mX_ready & mX_last (transfer of the final beat downstream).
  - Modulo 2^CNT_W: all-ones + 1 -> 0, no saturation or flag.
  - pkt_cnt0 and pkt_cnt1 may increment in the same cycle.
- Simultaneous events:
  - A beat accepted into X in the same cycle X's held beat is consumed: the new beat replaces it and mX_valid stays 1, with no bubble.
  - s_sel changes while BUSY: no effect.
  - s_valid low mid-packet: state held, no timeout.
- busy = (state == BUSY).

Test Plan:
- Reset, then 3-beat packet (s_sel=1, data 0xA0,0xA1,0xA2, last on beat 3), m1_ready=1 -> m1 emits 0xA0..0xA2 on consecutive cycles starting 1 cycle after first accept; m1_last only on 0xA2; pkt_cnt1=1; m0_valid never 1; busy high after beat 1 until beat 3 accepted.
- Packet to out0 (s_sel=0) with s_sel toggled to 1 on beats 2-4 of 4 -> all 4 beats on m0, pkt_cnt0=1, pkt_cnt1=0.
- m0_ready=0 while sending 2 beats to out0 -> first beat held stable on m0 (0x11, valid=1); s_ready drops; raising m0_ready resumes with no beat lost or duplicated.
- m0 stalled holding a beat; send single-beat packet (last=1) to out1 with m1_ready=1 -> passes in 1 cycle; pkt_cnt1 increments, pkt_cnt0 unchanged.
- CNT_W=8: send 256 single-beat packets to out0 -> pkt_cnt0 wraps to 0x00 after 0xFF.
- Assert rst_n=0 for 1 cycle after beat 2 of a 5-beat packet -> busy=0, both m*_valid=0, counters 0; next packet routes per fresh s_sel.

Source files
------------

// File: rtl/stream_demux2.sv
// rtl/stream_demux2.sv - one-to-two packet stream demultiplexer with per-output packet counters
//
// Steers each input packet (beats up to and including s_last) to output 0 or 1.
// The destination is s_sel sampled on the first beat and held for the rest of the packet.
// Each output has a one-entry register stage.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   s_data/s_last/s_sel/s_valid  input beat, packet end, destination, valid
//   s_ready                      input beat accepted when s_valid & s_ready
//   m0_data/m0_last/m0_valid     output 0 registered beat
//   m0_ready                     output 0 consumer ready
//   m1_data/m1_last/m1_valid     output 1 registered beat
//   m1_ready                     output 1 consumer ready
//   pkt_cnt0/pkt_cnt1            wrapping count of packets completed downstream per output
//   busy                         a packet is open (its first beat taken, its last not yet)

module stream_demux2 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_sel,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m0_last,
    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m1_last,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   route_q;
    logic   route_nxt;
    logic   route;
    logic   accept;

    assign accept = s_valid & s_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            route_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            route_q <= route_nxt;
        end
    end

    // Next-state logic; route is latched only when a multi-beat packet opens
    always_comb begin
        state_nxt = state;
        route_nxt = route_q;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!s_last) begin
                        state_nxt = BUSY;
                        route_nxt = s_sel;
                    end
                end
                BUSY: begin
                    if (s_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic; in IDLE the route follows s_sel directly so a packet's
    // first beat can be taken in the same cycle its destination is presented
    always_comb begin
        busy    = (state == BUSY);
        route   = (state == BUSY) ? route_q : s_sel;
        s_ready = 1'b0;
        if (rst_n) begin
            s_ready = route ? (~m1_valid | m1_ready) : (~m0_valid | m0_ready);
        end
    end

    // Output 0 register stage and packet counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m0_data  <= '0;
            m0_last  <= 1'b0;
            m0_valid <= 1'b0;
            pkt_cnt0 <= '0;
        end else begin
            if (accept && !route) begin
                m0_data  <= s_data;
                m0_last  <= s_last;
                m0_valid <= 1'b1;
            end else if (m0_ready) begin
                m0_valid <= 1'b0;
            end
            if (m0_valid && m0_ready && m0_last) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
        end
    end

    // Output 1 register stage and packet counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m1_data  <= '0;
            m1_last  <= 1'b0;
            m1_valid <= 1'b0;
            pkt_cnt1 <= '0;
        end else begin
            if (accept && route) begin
                m1_data  <= s_data;
                m1_last  <= s_last;
                m1_valid <= 1'b1;
            end else if (m1_ready) begin
                m1_valid <= 1'b0;
            end
            if (m1_valid && m1_ready && m1_last) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule
